sda_rx: RTL

Receive-side controller for the I2C slave interface: it samples raw SCL/SDA, detects START/STOP, shifts in address and data bytes, checks the 7-bit slave address and decides ACK/NACK. It produces the `sda_mode` select consumed by `sda_sel`, which drives the SDA pad. Mode encoding: 0 = release, 1 = drive ACK (0), 2 = NACK/release, 3 = transmit `tx_out`. It also strobes the transmit shifter during read transfers and hands received bytes to the downstream RX buffer.

---
 rtl/sda_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sda_rx.sv
// sda_rx: receive-side I2C slave controller. Synchronizes SCL/SDA, detects bus
// conditions, shifts in bytes, matches the slave address and picks the SDA drive mode.
module sda_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       rx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw_mode,
  output logic       start_found,
  output logic       stop_found,
  output logic       tx_shift,
  output logic       tx_load,
  output logic [1:0] sda_mode
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] DATA_ACK  = 3'd4;
  localparam logic [2:0] TX        = 3'd5;
  localparam logic [2:0] M_ACK     = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  localparam logic [1:0] MODE_REL  = 2'd0;
  localparam logic [1:0] MODE_ACK  = 2'd1;
  localparam logic [1:0] MODE_NACK = 2'd2;
  localparam logic [1:0] MODE_TX   = 2'd3;

  // [0] first sync flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_sync, sda_sync;
  logic       scl_rise, scl_fall, start_ev, stop_ev, sda_smp;

  logic [2:0] state;
  logic [3:0] cnt;
  logic [6:0] shreg;
  logic       nack;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_ev <= 1'b0;
      stop_ev  <= 1'b0;
      sda_smp  <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_in};
      sda_sync <= {sda_sync[1:0], sda_in};
      scl_rise <= scl_sync[1] & ~scl_sync[2];
      scl_fall <= ~scl_sync[1] & scl_sync[2];
      start_ev <= scl_sync[1] & sda_sync[2] & ~sda_sync[1];
      stop_ev  <= scl_sync[1] & ~sda_sync[2] & sda_sync[1];
      // SDA copy aligned with the registered SCL edge events
      sda_smp  <= sda_sync[1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      nack        <= 1'b0;
      sda_mode    <= MODE_REL;
      rx_data     <= '0;
      rw_mode     <= 1'b0;
      rx_valid    <= 1'b0;
      start_found <= 1'b0;
      stop_found  <= 1'b0;
      tx_shift    <= 1'b0;
      tx_load     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      start_found <= 1'b0;
      stop_found  <= 1'b0;
      tx_shift    <= 1'b0;
      tx_load     <= 1'b0;
      // STOP wins over START and over any SCL edge landing in the same cycle
      if (stop_ev) begin
        state      <= IDLE;
        sda_mode   <= MODE_REL;
        stop_found <= 1'b1;
        cnt        <= '0;
      end else if (start_ev) begin
        state       <= ADDR;
        sda_mode    <= MODE_REL;
        start_found <= 1'b1;
        cnt         <= '0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg <= {shreg[5:0], sda_smp};
            if (cnt == 4'd7) begin
              cnt <= '0;
              if (shreg == SLAVE_ADDR) begin
                rw_mode <= sda_smp;
                state   <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          // cnt[0] marks that the ACK bit is already on the bus
          ADDR_ACK: if (scl_fall) begin
            if (!cnt[0]) begin
              sda_mode <= MODE_ACK;
              cnt      <= 4'd1;
            end else begin
              cnt <= '0;
              if (rw_mode) begin
                sda_mode <= MODE_TX;
                tx_load  <= 1'b1;
                state    <= TX;
              end else begin
                sda_mode <= MODE_REL;
                state    <= DATA;
              end
            end
          end
          DATA: if (scl_rise) begin
            shreg <= {shreg[5:0], sda_smp};
            if (cnt == 4'd7) begin
              cnt   <= '0;
              state <= DATA_ACK;
              nack  <= rx_full;
              if (!rx_full) begin
                rx_data  <= {shreg, sda_smp};
                rx_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          DATA_ACK: if (scl_fall) begin
            if (!cnt[0]) begin
              sda_mode <= nack ? MODE_NACK : MODE_ACK;
              cnt      <= 4'd1;
            end else begin
              cnt      <= '0;
              sda_mode <= MODE_REL;
              state    <= nack ? WAIT_STOP : DATA;
            end
          end
          // First fall after load is bit 7 -> bit 6; the 8th fall ends bit 0
          TX: if (scl_fall) begin
            if (cnt == 4'd7) begin
              sda_mode <= MODE_NACK;
              cnt      <= '0;
              state    <= M_ACK;
            end else begin
              tx_shift <= 1'b1;
              cnt      <= cnt + 4'd1;
            end
          end
          M_ACK: begin
            if (scl_rise) begin
              nack <= sda_smp;
              cnt  <= 4'd1;
            end else if (scl_fall && cnt[0]) begin
              cnt <= '0;
              if (nack) begin
                sda_mode <= MODE_REL;
                state    <= WAIT_STOP;
              end else begin
                sda_mode <= MODE_TX;
                tx_load  <= 1'b1;
                state    <= TX;
              end
            end
          end
          IDLE, WAIT_STOP: ;
        endcase
      end
    end
  end

endmodule
